// File: rtl/demux_2bit_1x4_buf.sv
// Buffered 1-to-4 demultiplexer: one producer fans out to four independent channel FIFOs,
// each with its own valid/ready handshake toward its consumer.
module demux_2bit_1x4_buf #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             Clk_s,
    input  logic             Rstn_s,
    input  logic [WIDTH-1:0] In_s,
    input  logic [1:0]       Sel_s,
    input  logic             InValid_s,
    output logic             InReady_gs,
    output logic [WIDTH-1:0] OutA_gs,
    output logic [WIDTH-1:0] OutB_gs,
    output logic [WIDTH-1:0] OutC_gs,
    output logic [WIDTH-1:0] OutD_gs,
    output logic             OutValidA_gs,
    output logic             OutValidB_gs,
    output logic             OutValidC_gs,
    output logic             OutValidD_gs,
    input  logic             OutReadyA_s,
    input  logic             OutReadyB_s,
    input  logic             OutReadyC_s,
    input  logic             OutReadyD_s
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]         push_s;
    logic [3:0]         pop_s;
    logic [3:0]         valid_s;
    logic [3:0]         full_s;
    logic [3:0]         ready_s;
    logic [4*WIDTH-1:0] head_s;
    logic               accept_s;

    assign ready_s = {OutReadyD_s, OutReadyC_s, OutReadyB_s, OutReadyA_s};

    // Readiness depends only on the currently selected channel; a pop on that channel does not help.
    assign InReady_gs = ~full_s[Sel_s];
    assign accept_s   = InValid_s & InReady_gs;

    // Decode the accepted word into a one-hot push strobe and qualify consumer pops.
    always_comb begin
        push_s = 4'b0000;
        if (accept_s) begin
            push_s = 4'b0001 << Sel_s;
        end else begin
            push_s = 4'b0000;
        end
        pop_s = valid_s & ready_s;
    end

    for (genvar ch = 0; ch < 4; ch++) begin : g_ch
        logic [WIDTH-1:0] mem_r [DEPTH];
        logic [AW-1:0]    wr_ptr_r;
        logic [AW-1:0]    rd_ptr_r;
        logic [CW-1:0]    count_r;

        // Channel FIFO storage, power-of-two pointers wrapping naturally, and occupancy count.
        always_ff @(posedge Clk_s or negedge Rstn_s) begin
            if (!Rstn_s) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count_r  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_r[i] <= '0;
                end
            end else begin
                if (push_s[ch]) begin
                    mem_r[wr_ptr_r] <= In_s;
                    wr_ptr_r        <= wr_ptr_r + AW'(1);
                end
                if (pop_s[ch]) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                case ({push_s[ch], pop_s[ch]})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
            end
        end

        assign valid_s[ch] = (count_r != CW'(0));
        assign full_s[ch]  = (count_r == CW'(DEPTH));
        // Head word is masked to zero when empty so stale storage never leaks out.
        assign head_s[ch*WIDTH +: WIDTH] = valid_s[ch] ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    end

    assign OutA_gs      = head_s[0*WIDTH +: WIDTH];
    assign OutB_gs      = head_s[1*WIDTH +: WIDTH];
    assign OutC_gs      = head_s[2*WIDTH +: WIDTH];
    assign OutD_gs      = head_s[3*WIDTH +: WIDTH];
    assign OutValidA_gs = valid_s[0];
    assign OutValidB_gs = valid_s[1];
    assign OutValidC_gs = valid_s[2];
    assign OutValidD_gs = valid_s[3];

endmodule

// File: tb/tb_demux_2bit_1x4_buf.sv
// Randomized and directed bench for demux_2bit_1x4_buf against a queue-based channel model.
module tb_demux_2bit_1x4_buf;

    localparam int DEPTH = 2;

    logic            Clk_s;
    logic            Rstn_s;
    logic [1:0]      In_s;
    logic [1:0]      Sel_s;
    logic            InValid_s;
    logic            InReady_gs;
    logic [3:0]      rdy;
    logic [1:0]      OutA_gs, OutB_gs, OutC_gs, OutD_gs;
    logic            OutValidA_gs, OutValidB_gs, OutValidC_gs, OutValidD_gs;
    logic [3:0][1:0] dut_out;
    logic [3:0]      dut_valid;

    logic [1:0]      mq [4][$];
    int              n_cmp;
    int              n_fail;

    demux_2bit_1x4_buf #(.WIDTH(2), .DEPTH(DEPTH)) dut (
        .Clk_s(Clk_s), .Rstn_s(Rstn_s), .In_s(In_s), .Sel_s(Sel_s),
        .InValid_s(InValid_s), .InReady_gs(InReady_gs),
        .OutA_gs(OutA_gs), .OutB_gs(OutB_gs), .OutC_gs(OutC_gs), .OutD_gs(OutD_gs),
        .OutValidA_gs(OutValidA_gs), .OutValidB_gs(OutValidB_gs),
        .OutValidC_gs(OutValidC_gs), .OutValidD_gs(OutValidD_gs),
        .OutReadyA_s(rdy[0]), .OutReadyB_s(rdy[1]), .OutReadyC_s(rdy[2]), .OutReadyD_s(rdy[3])
    );

    assign dut_out   = {OutD_gs, OutC_gs, OutB_gs, OutA_gs};
    assign dut_valid = {OutValidD_gs, OutValidC_gs, OutValidB_gs, OutValidA_gs};

    initial Clk_s = 1'b0;
    always #5 Clk_s = ~Clk_s;

    // Advance one clock edge and apply the channel rules to the model using pre-edge inputs.
    task automatic tick();
        int  s;
        bit  acc;
        @(posedge Clk_s);
        s   = int'(Sel_s);
        acc = InValid_s && (mq[s].size() < DEPTH);
        for (int ch = 0; ch < 4; ch++) begin
            if (mq[ch].size() > 0 && rdy[ch]) void'(mq[ch].pop_front());
        end
        if (acc) mq[s].push_back(In_s);
        #1;
    endtask

    task automatic idle_inputs();
        InValid_s = 1'b0;
        Sel_s     = 2'd0;
        In_s      = 2'd0;
        rdy       = 4'b0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        Rstn_s = 1'b0;
        #12;
        Rstn_s = 1'b1;
        tick();
        for (int ch = 0; ch < 4; ch++) begin
            n_cmp++;
            if (dut_valid[ch] !== 1'b0 || dut_out[ch] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_init ch%0d: got valid=%b out=%0d expected valid=0 out=0", ch, dut_valid[ch], dut_out[ch]);
            end
        end
        n_cmp++;
        if (InReady_gs !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_init_ready: got %b expected 1", InReady_gs);
        end
        // Buffer words in A and B, then pull reset between edges.
        for (int k = 0; k < 3; k++) begin
            InValid_s = 1'b1;
            Sel_s     = (k == 2) ? 2'd1 : 2'd0;
            In_s      = 2'(k + 1);
            tick();
        end
        idle_inputs();
        #2;
        Rstn_s = 1'b0;
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            mq[ch].delete();
            n_cmp++;
            if (dut_valid[ch] !== 1'b0 || dut_out[ch] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_async ch%0d: got valid=%b out=%0d expected valid=0 out=0", ch, dut_valid[ch], dut_out[ch]);
            end
        end
        n_cmp++;
        if (InReady_gs !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async_ready: got %b expected 1", InReady_gs);
        end
        #3;
        Rstn_s = 1'b1;
        tick();
        tick();
        for (int ch = 0; ch < 4; ch++) begin
            n_cmp++;
            if (dut_valid[ch] !== 1'b0 || dut_out[ch] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_after ch%0d: got valid=%b out=%0d expected valid=0 out=0", ch, dut_valid[ch], dut_out[ch]);
            end
        end
    endtask

    task automatic test_routing();
        logic [1:0] words [4];
        words[0] = 2'b01; words[1] = 2'b10; words[2] = 2'b11; words[3] = 2'b00;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            InValid_s = 1'b1;
            Sel_s     = 2'(k);
            In_s      = words[k];
            #4;
            n_cmp++;
            if (InReady_gs !== 1'b1) begin
                n_fail++;
                $display("FAIL routing_ready ch%0d: got %b expected 1", k, InReady_gs);
            end
            tick();
            n_cmp++;
            if (dut_valid[k] !== 1'b1 || dut_out[k] !== words[k]) begin
                n_fail++;
                $display("FAIL routing_latency ch%0d: got valid=%b out=%0d expected valid=1 out=%0d", k, dut_valid[k], dut_out[k], words[k]);
            end
        end
        idle_inputs();
        #4;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (dut_valid[k] !== 1'b1 || dut_out[k] !== words[k]) begin
                n_fail++;
                $display("FAIL routing_hold ch%0d: got valid=%b out=%0d expected valid=1 out=%0d", k, dut_valid[k], dut_out[k], words[k]);
            end
        end
    endtask

    task automatic test_full();
        logic [1:0] w [3];
        idle_inputs();
        rdy = 4'b1111;
        tick();
        rdy = 4'b0000;
        for (int i = 0; i < 3; i++) w[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 3; i++) begin
            InValid_s = 1'b1;
            Sel_s     = 2'd1;
            In_s      = w[i];
            #4;
            n_cmp++;
            if (InReady_gs !== ((i < 2) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL full_ready push%0d: got %b expected %b", i, InReady_gs, (i < 2));
            end
            tick();
        end
        n_cmp++;
        if (OutValidB_gs !== 1'b1 || OutB_gs !== w[0]) begin
            n_fail++;
            $display("FAIL full_head: got valid=%b out=%0d expected valid=1 out=%0d", OutValidB_gs, OutB_gs, w[0]);
        end
        Sel_s = 2'd2;
        #1;
        n_cmp++;
        if (InReady_gs !== 1'b1) begin
            n_fail++;
            $display("FAIL full_other_ready: got %b expected 1", InReady_gs);
        end
        // Full with a same-cycle pop still refuses the push.
        Sel_s = 2'd1;
        In_s  = w[2];
        rdy   = 4'b0010;
        #3;
        n_cmp++;
        if (InReady_gs !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_refuse: got %b expected 0", InReady_gs);
        end
        tick();
        n_cmp++;
        if (OutValidB_gs !== 1'b1 || OutB_gs !== w[1] || InReady_gs !== 1'b1) begin
            n_fail++;
            $display("FAIL fullpop_count1: got valid=%b out=%0d ready=%b expected valid=1 out=%0d ready=1", OutValidB_gs, OutB_gs, InReady_gs, w[1]);
        end
        rdy = 4'b0000;
        tick();
        n_cmp++;
        if (InReady_gs !== 1'b0 || OutB_gs !== w[1]) begin
            n_fail++;
            $display("FAIL fullpop_retry: got ready=%b out=%0d expected ready=0 out=%0d", InReady_gs, OutB_gs, w[1]);
        end
        idle_inputs();
        rdy = 4'b0010;
        tick();
        n_cmp++;
        if (OutValidB_gs !== 1'b1 || OutB_gs !== w[2]) begin
            n_fail++;
            $display("FAIL fullpop_second: got valid=%b out=%0d expected valid=1 out=%0d", OutValidB_gs, OutB_gs, w[2]);
        end
        tick();
        n_cmp++;
        if (OutValidB_gs !== 1'b0 || OutB_gs !== 2'd0) begin
            n_fail++;
            $display("FAIL fullpop_drained: got valid=%b out=%0d expected valid=0 out=0", OutValidB_gs, OutB_gs);
        end
        rdy = 4'b0000;
    endtask

    task automatic test_wrap_order();
        logic [1:0] got [$];
        int idx;
        int cyc;
        bit acc;
        idle_inputs();
        rdy = 4'b0100;
        tick();
        idx = 0;
        cyc = 0;
        while (got.size() < 8 && cyc < 100) begin
            InValid_s = (idx < 8);
            Sel_s     = 2'd2;
            In_s      = 2'(idx % 4);
            rdy       = (cyc % 2 == 0) ? 4'b0100 : 4'b0000;
            #4;
            n_cmp++;
            if (OutValidC_gs !== (mq[2].size() > 0) || OutC_gs !== ((mq[2].size() > 0) ? mq[2][0] : 2'd0)) begin
                n_fail++;
                $display("FAIL wrap_head cyc%0d: got valid=%b out=%0d expected valid=%b", cyc, OutValidC_gs, OutC_gs, (mq[2].size() > 0));
            end
            if (OutValidC_gs && rdy[2]) got.push_back(OutC_gs);
            acc = InValid_s && (mq[2].size() < DEPTH);
            tick();
            if (acc) idx++;
            cyc++;
        end
        n_cmp++;
        if (got.size() != 8) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d words expected 8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_cmp++;
            if (got[i] !== 2'(i % 4)) begin
                n_fail++;
                $display("FAIL wrap_order word%0d: got %0d expected %0d", i, got[i], i % 4);
            end
        end
        idle_inputs();
    endtask

    task automatic test_concurrency();
        logic [1:0] a0, c0, d0, d1;
        a0 = 2'($urandom_range(0, 3)); c0 = 2'($urandom_range(0, 3));
        d0 = 2'($urandom_range(0, 3)); d1 = 2'($urandom_range(0, 3));
        idle_inputs();
        rdy = 4'b1111;
        tick();
        tick();
        rdy = 4'b0000;
        InValid_s = 1'b1;
        Sel_s = 2'd2; In_s = c0; tick();
        Sel_s = 2'd3; In_s = d0; tick();
        Sel_s = 2'd3; In_s = d1; tick();
        Sel_s = 2'd0; In_s = a0;
        rdy   = 4'b1100;
        tick();
        idle_inputs();
        n_cmp++;
        if (OutValidA_gs !== 1'b1 || OutA_gs !== a0) begin
            n_fail++;
            $display("FAIL conc_push_a: got valid=%b out=%0d expected valid=1 out=%0d", OutValidA_gs, OutA_gs, a0);
        end
        n_cmp++;
        if (OutValidC_gs !== 1'b0 || OutValidD_gs !== 1'b1 || OutD_gs !== d1 || OutValidB_gs !== 1'b0) begin
            n_fail++;
            $display("FAIL conc_pop_cd: got vC=%b vD=%b D=%0d vB=%b expected vC=0 vD=1 D=%0d vB=0", OutValidC_gs, OutValidD_gs, OutD_gs, OutValidB_gs, d1);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            InValid_s = ($urandom_range(0, 3) != 0);
            Sel_s     = 2'($urandom_range(0, 3));
            In_s      = 2'($urandom_range(0, 3));
            rdy       = 4'($urandom_range(0, 15));
            #4;
            n_cmp++;
            if (InReady_gs !== (mq[Sel_s].size() != DEPTH)) begin
                n_fail++;
                $display("FAIL rand_ready cyc%0d: got %b expected %b", cyc, InReady_gs, (mq[Sel_s].size() != DEPTH));
            end
            for (int ch = 0; ch < 4; ch++) begin
                n_cmp++;
                if (dut_valid[ch] !== (mq[ch].size() > 0) || dut_out[ch] !== ((mq[ch].size() > 0) ? mq[ch][0] : 2'd0)) begin
                    n_fail++;
                    $display("FAIL rand_out cyc%0d ch%0d: got valid=%b out=%0d expected valid=%b out=%0d", cyc, ch, dut_valid[ch], dut_out[ch], (mq[ch].size() > 0), ((mq[ch].size() > 0) ? mq[ch][0] : 2'd0));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        Rstn_s = 1'b0;
        idle_inputs();
        test_reset();
        test_routing();
        test_full();
        test_wrap_order();
        test_concurrency();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
